// File: rtl/tetris_board.sv
// tetris_board: playfield engine for a 20x10 Tetris grid.
// It keeps the locked cells and the one falling piece, applies move,
// rotate and gravity commands with collision checks, locks pieces,
// clears full rows one at a time and detects game over.
//
// Ports
//   clk_40MHz      system clock
//   reset          synchronous, active-low reset
//   move_left      single-cycle command pulse
//   move_right     single-cycle command pulse
//   rotate         single-cycle pulse, rotate clockwise
//   soft_drop      single-cycle pulse, move down one row
//   tick           gravity pulse, same effect as soft_drop
//   piece_type     next piece (0..6 = I,O,T,S,Z,J,L; 7 -> I), sampled in SPAWN
//   Blocks         registered occupancy, bit row*10+col (row 0 top, col 0 left)
//   busy           high whenever the engine is not accepting commands
//   game_over      sticky until reset
//   lines_cleared  running count of cleared rows, wraps
module tetris_board #(
   parameter int ROWS      = 20,
   parameter int COLS      = 10,
   parameter int SPAWN_COL = 3
) (
   input  logic                 clk_40MHz,
   input  logic                 reset,
   input  logic                 move_left,
   input  logic                 move_right,
   input  logic                 rotate,
   input  logic                 soft_drop,
   input  logic                 tick,
   input  logic [2:0]           piece_type,
   output logic [ROWS*COLS-1:0] Blocks,
   output logic                 busy,
   output logic                 game_over,
   output logic [15:0]          lines_cleared
);

   localparam int CELLS = ROWS * COLS;
   localparam logic signed [4:0] SPAWN_X = 5'(SPAWN_COL);

   typedef enum logic [2:0] {SPAWN, PLAY, CHECK, CLEAR, OVER} state_t;

   state_t             state_reg, state_next;
   logic [CELLS-1:0]   locked_reg, locked_next;
   logic [CELLS-1:0]   blocks_reg, blocks_next;
   logic [2:0]         type_reg, type_next;
   logic signed [4:0]  px_reg, px_next;
   logic [5:0]         py_reg, py_next;
   logic [1:0]         rot_reg, rot_next;
   logic [4:0]         ptr_reg, ptr_next;
   logic               game_over_reg, game_over_next;
   logic [15:0]        lines_reg, lines_next;

   // Rotation-0 shape of each piece inside the 4x4 box, cell (r,c) at bit r*4+c.
   function automatic logic [15:0] base_mask(input logic [2:0] t);
      case (t)
         3'd1:    return 16'h0066;   // O
         3'd2:    return 16'h0072;   // T
         3'd3:    return 16'h0036;   // S
         3'd4:    return 16'h0063;   // Z
         3'd5:    return 16'h0071;   // J
         3'd6:    return 16'h0074;   // L
         default: return 16'h00F0;   // I (also code 7)
      endcase
   endfunction

   // One clockwise quarter turn: new[r][c] = old[3-c][r].
   function automatic logic [15:0] rotate_cw(input logic [15:0] m);
      logic [15:0] n;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            n[r*4+c] = m[(3-c)*4+r];
      return n;
   endfunction

   function automatic logic [15:0] piece_mask(input logic [2:0] t, input logic [1:0] k);
      logic [15:0] m;
      m = base_mask(t);
      for (int i = 0; i < 3; i++)
         if (i < int'(k)) m = rotate_cw(m);
      return m;
   endfunction

   // True if any piece cell falls outside the field or on a locked cell.
   // The box row is unsigned, so only the bottom edge needs a row check.
   function automatic logic collides(input logic [15:0] m, input logic signed [4:0] x,
                                     input logic [5:0] y, input logic [CELLS-1:0] grid);
      int row, col;
      logic hit;
      hit = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (m[r*4+c]) begin
               col = int'(x) + c;
               row = int'(y) + r;
               if (col < 0 || col >= COLS || row >= ROWS) hit = 1'b1;
               else if (grid[row*COLS+col])               hit = 1'b1;
            end
      return hit;
   endfunction

   // Piece cells expanded onto the field; off-field cells are dropped.
   function automatic logic [CELLS-1:0] place_cells(input logic [15:0] m,
                                                    input logic signed [4:0] x,
                                                    input logic [5:0] y);
      int row, col;
      logic [CELLS-1:0] v;
      v = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (m[r*4+c]) begin
               col = int'(x) + c;
               row = int'(y) + r;
               if (col >= 0 && col < COLS && row < ROWS) v[row*COLS+col] = 1'b1;
            end
      return v;
   endfunction

   logic [2:0]        spawn_type;
   logic [15:0]       cur_mask, rot_mask;
   logic [CELLS-1:0]  cur_cells;
   logic signed [4:0] px_left, px_right;
   logic [5:0]        py_down;
   logic [1:0]        rot_inc;
   logic              spawn_hit, down_hit, rot_hit, left_hit, right_hit;
   logic              row_full;
   logic [CELLS-1:0]  shifted;

   assign spawn_type = (piece_type == 3'd7) ? 3'd0 : piece_type;
   assign px_left    = px_reg - 5'sd1;
   assign px_right   = px_reg + 5'sd1;
   assign py_down    = py_reg + 6'd1;
   assign rot_inc    = rot_reg + 2'd1;
   assign cur_mask   = piece_mask(type_reg, rot_reg);
   assign rot_mask   = piece_mask(type_reg, rot_inc);
   assign cur_cells  = place_cells(cur_mask, px_reg, py_reg);
   assign spawn_hit  = collides(base_mask(spawn_type), SPAWN_X, 6'd0, locked_reg);
   assign down_hit   = collides(cur_mask, px_reg, py_down, locked_reg);
   assign rot_hit    = collides(rot_mask, px_reg, py_reg, locked_reg);
   assign left_hit   = collides(cur_mask, px_left, py_reg, locked_reg);
   assign right_hit  = collides(cur_mask, px_right, py_reg, locked_reg);
   assign row_full   = &locked_reg[ptr_reg*COLS +: COLS];

   // Grid with the row at ptr removed: rows above it move down one, row 0 empties,
   // rows below ptr keep their contents.
   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_shift
         if (gi == 0) begin : g_top
            assign shifted[0 +: COLS] = '0;
         end else begin : g_row
            assign shifted[gi*COLS +: COLS] = (5'(gi) > ptr_reg) ? locked_reg[gi*COLS +: COLS]
                                                                 : locked_reg[(gi-1)*COLS +: COLS];
         end
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      locked_next    = locked_reg;
      type_next      = type_reg;
      px_next        = px_reg;
      py_next        = py_reg;
      rot_next       = rot_reg;
      ptr_next       = ptr_reg;
      game_over_next = game_over_reg;
      lines_next     = lines_reg;
      case (state_reg)
         SPAWN: begin
            type_next = spawn_type;
            px_next   = SPAWN_X;
            py_next   = 6'd0;
            rot_next  = 2'd0;
            if (spawn_hit) begin
               game_over_next = 1'b1;
               state_next     = OVER;
            end else begin
               state_next = PLAY;
            end
         end
         PLAY: begin
            // One command per cycle; lower-priority pulses in the same cycle are lost.
            if (soft_drop | tick) begin
               if (!down_hit) begin
                  py_next = py_down;
               end else begin
                  locked_next = locked_reg | cur_cells;
                  ptr_next    = 5'(ROWS - 1);
                  state_next  = CHECK;
               end
            end else if (rotate) begin
               if (!rot_hit) rot_next = rot_inc;
            end else if (move_left) begin
               if (!left_hit) px_next = px_left;
            end else if (move_right) begin
               if (!right_hit) px_next = px_right;
            end
         end
         CHECK: begin
            if (row_full) begin
               locked_next = shifted;
               lines_next  = lines_reg + 16'd1;
               state_next  = CLEAR;
            end else if (ptr_reg == 5'd0) begin
               state_next = SPAWN;
            end else begin
               ptr_next = ptr_reg - 5'd1;
            end
         end
         CLEAR: state_next = CHECK;   // same ptr again: the shifted-in row may be full too
         default: ;                   // OVER: frozen until reset
      endcase
      blocks_next = locked_reg | ((state_reg == PLAY) ? cur_cells : '0);
   end

   always_ff @(posedge clk_40MHz) begin
      if (!reset) begin
         state_reg     <= SPAWN;
         locked_reg    <= '0;
         blocks_reg    <= '0;
         type_reg      <= 3'd0;
         px_reg        <= SPAWN_X;
         py_reg        <= 6'd0;
         rot_reg       <= 2'd0;
         ptr_reg       <= 5'(ROWS - 1);
         game_over_reg <= 1'b0;
         lines_reg     <= 16'd0;
      end else begin
         state_reg     <= state_next;
         locked_reg    <= locked_next;
         blocks_reg    <= blocks_next;
         type_reg      <= type_next;
         px_reg        <= px_next;
         py_reg        <= py_next;
         rot_reg       <= rot_next;
         ptr_reg       <= ptr_next;
         game_over_reg <= game_over_next;
         lines_reg     <= lines_next;
      end
   end

   assign Blocks        = blocks_reg;
   assign busy          = (state_reg != PLAY);
   assign game_over     = game_over_reg;
   assign lines_cleared = lines_reg;

endmodule
